// File: rtl/hamming_rx_controller.sv
// ---------------------------------------------------------------------------
// hamming_rx_controller
//
// Receive-side controller for a Hamming(11,7) link. Serial bits are
// assembled into 11-bit codewords (first bit = position 1). Each codeword is
// decoded in a registered syndrome/correction stage. The result is pushed
// into a 2-entry output FIFO with a valid/ready handshake. Saturating
// counters track corrected and uncorrectable words.
//
// Ports
//   clk, rst       : clock (rising edge) and asynchronous active-high reset
//   bit_in         : serial code bit, sampled when bit_valid=1
//   bit_valid      : qualifies bit_in
//   frame_sync     : drop the partial codeword and restart the bit count
//   out_data       : corrected 7-bit data word at the FIFO head
//   out_syndrome   : syndrome of the head word
//   out_corrected  : head word had a single-bit error that was fixed
//   out_uncorr     : head word syndrome was 12..15 (data not corrected)
//   out_valid      : FIFO non-empty
//   out_ready      : consumer takes the head word on this edge
//   overflow       : sticky, a decoded word was dropped on a full FIFO
//   corr_count     : saturating count of corrected words
//   uncorr_count   : saturating count of uncorrectable words
// ---------------------------------------------------------------------------
module hamming_rx_controller #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_sync,
    output logic [6:0]       out_data,
    output logic [3:0]       out_syndrome,
    output logic             out_corrected,
    output logic             out_uncorr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count
);

    typedef struct packed {
        logic [6:0] data;
        logic [3:0] syndrome;
        logic       corrected;
        logic       uncorr;
    } entry_t;

    // ---------------- bit assembly ----------------
    logic [3:0]  cnt_q, cnt_d;
    logic [10:0] shift_q, shift_d;
    logic [10:0] cw_q, cw_d;
    logic        cw_valid_q, cw_valid_d;

    // NOTE: combinational blocks assign every output a default first, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        cw_d       = cw_q;
        cw_valid_d = 1'b0;
        if (frame_sync) begin
            // Realign wins over a bit on the same edge; that bit is discarded.
            cnt_d   = '0;
            shift_d = '0;
        end else if (bit_valid) begin
            // Shift right: after 11 bits the first bit sits at bit 0 (position 1).
            shift_d = {bit_in, shift_q[10:1]};
            if (cnt_q == 4'd10) begin
                cnt_d      = '0;
                cw_d       = shift_d;
                cw_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            cw_q       <= '0;
            cw_valid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            cw_q       <= cw_d;
            cw_valid_q <= cw_valid_d;
        end
    end

    // ---------------- syndrome / correction ----------------
    // Position k lives in cw_q[k-1].
    logic [3:0]  syn;
    logic [10:0] cw_fix;
    entry_t      dec_d, dec_q;
    logic        dec_valid_q;

    always_comb begin
        syn[0] = cw_q[0] ^ cw_q[2] ^ cw_q[4] ^ cw_q[6] ^ cw_q[8] ^ cw_q[10];
        syn[1] = cw_q[1] ^ cw_q[2] ^ cw_q[5] ^ cw_q[6] ^ cw_q[9] ^ cw_q[10];
        syn[2] = cw_q[3] ^ cw_q[4] ^ cw_q[5] ^ cw_q[6];
        syn[3] = cw_q[7] ^ cw_q[8] ^ cw_q[9] ^ cw_q[10];

        cw_fix          = cw_q;
        dec_d.corrected = 1'b0;
        dec_d.uncorr    = 1'b0;
        if (syn >= 4'd12) begin
            dec_d.uncorr = 1'b1;
        end else if (syn != 4'd0) begin
            cw_fix          = cw_q ^ (11'(1) << (syn - 4'd1));
            dec_d.corrected = 1'b1;
        end
        dec_d.syndrome = syn;
        dec_d.data     = {cw_fix[10], cw_fix[9], cw_fix[8], cw_fix[6],
                          cw_fix[5], cw_fix[4], cw_fix[2]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q       <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            dec_q       <= dec_d;
            dec_valid_q <= cw_valid_q;
        end
    end

    // ---------------- output FIFO ----------------
    entry_t     mem_q [2];
    logic       rd_ptr_q, wr_ptr_q;
    logic [1:0] count_q;
    logic       push, pop;
    entry_t     head;

    assign pop  = out_valid && out_ready;
    // When full, a same-edge pop frees the slot being overwritten.
    assign push = dec_valid_q && ((count_q != 2'd2) || pop);

    // NOTE: the storage array has no reset; the outputs are gated by
    // out_valid, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dec_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= '0;
            overflow     <= 1'b0;
            corr_count   <= '0;
            uncorr_count <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push && !pop) begin
                count_q <= count_q + 2'd1;
            end else if (pop && !push) begin
                count_q <= count_q - 2'd1;
            end
            if (dec_valid_q && !push) begin
                overflow <= 1'b1;
            end
            if (push && dec_q.corrected && (corr_count != '1)) begin
                corr_count <= corr_count + 1'b1;
            end
            if (push && dec_q.uncorr && (uncorr_count != '1)) begin
                uncorr_count <= uncorr_count + 1'b1;
            end
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign out_valid     = (count_q != 2'd0);
    assign out_data      = out_valid ? head.data      : '0;
    assign out_syndrome  = out_valid ? head.syndrome  : '0;
    assign out_corrected = out_valid ? head.corrected : 1'b0;
    assign out_uncorr    = out_valid ? head.uncorr    : 1'b0;

endmodule

// File: tb/tb_hamming_rx_controller.sv
// ---------------------------------------------------------------------------
// tb_hamming_rx_controller
//
// Directed bench for hamming_rx_controller. Inputs change on the falling
// edge and outputs are sampled on the falling edge, away from the active
// rising edge. Expected values are hand-computed Hamming(11,7) results.
// ---------------------------------------------------------------------------
module tb_hamming_rx_controller;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_in;
    logic             bit_valid;
    logic             frame_sync;
    logic [6:0]       out_data;
    logic [3:0]       out_syndrome;
    logic             out_corrected;
    logic             out_uncorr;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;
    logic [CNT_W-1:0] corr_count;
    logic [CNT_W-1:0] uncorr_count;

    int errors = 0;
    int checks = 0;

    hamming_rx_controller #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .frame_sync    (frame_sync),
        .out_data      (out_data),
        .out_syndrome  (out_syndrome),
        .out_corrected (out_corrected),
        .out_uncorr    (out_uncorr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .overflow      (overflow),
        .corr_count    (corr_count),
        .uncorr_count  (uncorr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Send the first n bits of cw, position 1 (bit 0) first; returns on the
    // falling edge after the last sampling edge.
    task automatic send_bits(input logic [10:0] cw, input int n);
        for (int i = 0; i < n; i++) begin
            bit_in    = cw[i];
            bit_valid = 1'b1;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Full codeword with out_ready=1: check latency, head fields, then the pop.
    task automatic send_and_check(input string tag, input logic [10:0] cw,
                                  input logic [6:0] e_data, input logic [3:0] e_syn,
                                  input logic e_corr, input logic e_unc);
        send_bits(cw, 11);
        @(negedge clk);                       // E+1 passed
        check({tag, ".valid_e1"}, out_valid, 0);
        @(negedge clk);                       // E+2 passed
        check({tag, ".valid_e2"}, out_valid, 1);
        check({tag, ".data"}, out_data, e_data);
        check({tag, ".syn"}, out_syndrome, e_syn);
        check({tag, ".corr"}, out_corrected, e_corr);
        check({tag, ".unc"}, out_uncorr, e_unc);
        @(negedge clk);                       // popped
        check({tag, ".popped"}, out_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        frame_sync = 1'b0;
        out_ready  = 1'b1;
        do_reset();

        // Reset state
        check("rst.valid", out_valid, 0);
        check("rst.data", out_data, 0);
        check("rst.syn", out_syndrome, 0);
        check("rst.ovf", overflow, 0);
        check("rst.corr_cnt", corr_count, 0);
        check("rst.unc_cnt", uncorr_count, 0);

        // Decode cases
        send_and_check("zero",  11'h000, 7'h00, 4'd0,  1'b0, 1'b0);
        send_and_check("p5err", 11'h017, 7'h01, 4'd5,  1'b1, 1'b0);
        check("p5err.corr_cnt", corr_count, 1);
        send_and_check("ones",  11'h7FF, 7'h7F, 4'd0,  1'b0, 1'b0);
        send_and_check("unc",   11'h088, 7'h00, 4'd12, 1'b0, 1'b1);
        check("unc.unc_cnt", uncorr_count, 1);
        send_and_check("dbl",   11'h004, 7'h00, 4'd3,  1'b1, 1'b0);
        check("dbl.corr_cnt", corr_count, 2);
        check("pre_ovf.ovf", overflow, 0);

        // Backpressure: two buffered, third dropped
        out_ready = 1'b0;
        send_bits(11'h000, 11);
        send_bits(11'h7FF, 11);
        send_bits(11'h017, 11);
        @(negedge clk);
        @(negedge clk);
        check("ovf.flag", overflow, 1);
        check("ovf.valid", out_valid, 1);
        check("ovf.head0", out_data, 7'h00);
        check("ovf.corr_cnt", corr_count, 2);
        out_ready = 1'b1;
        @(negedge clk);
        check("ovf.head1", out_data, 7'h7F);
        check("ovf.valid1", out_valid, 1);
        @(negedge clk);
        check("ovf.drained", out_valid, 0);

        // frame_sync after 5 partial bits; sync-edge bit must be ignored
        send_bits(11'h000, 5);
        frame_sync = 1'b1;
        bit_valid  = 1'b1;
        bit_in     = 1'b0;
        @(negedge clk);
        frame_sync = 1'b0;
        bit_valid  = 1'b0;
        send_and_check("sync", 11'h7FF, 7'h7F, 4'd0, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        check("sync.one_word", out_valid, 0);

        // Async reset mid-codeword with a buffered word and nonzero state
        out_ready = 1'b0;
        send_bits(11'h017, 11);
        @(negedge clk);
        @(negedge clk);
        check("arst.pre_valid", out_valid, 1);
        send_bits(11'h7FF, 6);
        #2 rst = 1'b1;
        #1;
        check("arst.valid", out_valid, 0);
        check("arst.data", out_data, 0);
        check("arst.syn", out_syndrome, 0);
        check("arst.corr", out_corrected, 0);
        check("arst.ovf", overflow, 0);
        check("arst.corr_cnt", corr_count, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        send_and_check("post_rst", 11'h7FF, 7'h7F, 4'd0, 1'b0, 1'b0);

        // Saturation: 260 single-error words
        for (int n = 0; n < 260; n++) begin
            send_bits(11'h017, 11);
        end
        repeat (3) @(negedge clk);
        check("sat.corr_cnt", corr_count, 255);
        check("sat.unc_cnt", uncorr_count, 0);
        check("sat.ovf", overflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
